// File: rtl/alu_sched.sv
// alu_sched: time-shares one combinational 4-bit ALU between two requesters.
// Round-robin (or fixed-priority) grant, valid/ready on both sides, and 8-bit
// ops executed as two nibble passes with the carry chained in arithmetic mode.
module alu_sched #(
  parameter bit WIDE_EN = 1'b1,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_c_in,
  input  logic [1:0]  req_mode,
  input  logic [5:0]  req_op,
  input  logic [1:0]  req_wide,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_c_in,
  output logic        alu_mode,
  output logic [2:0]  alu_op,
  input  logic [3:0]  alu_out,
  input  logic        alu_c_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_c_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cap_a, cap_b;
  logic [2:0]  cap_op;
  logic        cap_c, cap_mode, cap_wide, cap_id;
  logic [7:0]  res;
  logic        cy;
  // rr_ptr holds the last granted id; served marks that a grant has happened
  // since reset, so the very first tie goes to requester 0.
  logic        rr_ptr, served;
  logic        gnt_id, accept;

  // Grant selection: tie -> the requester not served last (or 0 if fixed priority)
  always_comb begin
    gnt_id = 1'b0;
    if (req_valid == 2'b11)
      gnt_id = (RR_EN && served) ? ~rr_ptr : 1'b0;
    else if (req_valid[1])
      gnt_id = 1'b1;
    accept = (state == IDLE) && (|req_valid);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = LO;
      LO:      state_nxt = cap_wide ? HI : RESP;
      HI:      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant strobe, ALU drive per pass, response view of captured regs
  always_comb begin
    req_ready = 2'b00;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_c_in  = 1'b0;
    alu_mode  = 1'b0;
    alu_op    = 3'h0;
    if (accept) req_ready[gnt_id] = 1'b1;
    case (state)
      LO: begin
        alu_a    = cap_a[3:0];
        alu_b    = cap_b[3:0];
        alu_c_in = cap_c;
        alu_mode = cap_mode;
        alu_op   = cap_op;
      end
      HI: begin
        alu_a    = cap_a[7:4];
        alu_b    = cap_b[7:4];
        // carry only chains between nibbles for arithmetic ops
        alu_c_in = cap_mode ? cy : cap_c;
        alu_mode = cap_mode;
        alu_op   = cap_op;
      end
      default: ;
    endcase
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    rsp_id    = cap_id;
    rsp_data  = {cap_wide ? res[7:4] : 4'h0, res[3:0]};
    rsp_c_out = cy;
  end

  // Capture the granted request, accumulate pass results, track rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_a    <= 8'h00;
      cap_b    <= 8'h00;
      cap_op   <= 3'h0;
      cap_c    <= 1'b0;
      cap_mode <= 1'b0;
      cap_wide <= 1'b0;
      cap_id   <= 1'b0;
      res      <= 8'h00;
      cy       <= 1'b0;
      rr_ptr   <= 1'b0;
      served   <= 1'b0;
    end else begin
      if (accept) begin
        cap_a    <= gnt_id ? req_a[15:8] : req_a[7:0];
        cap_b    <= gnt_id ? req_b[15:8] : req_b[7:0];
        cap_op   <= gnt_id ? req_op[5:3] : req_op[2:0];
        cap_c    <= req_c_in[gnt_id];
        cap_mode <= req_mode[gnt_id];
        cap_wide <= req_wide[gnt_id] & WIDE_EN;
        cap_id   <= gnt_id;
        rr_ptr   <= gnt_id;
        served   <= 1'b1;
      end
      if (state == LO) begin
        res[3:0] <= alu_out;
        cy       <= alu_c_out;
      end
      if (state == HI) begin
        res[7:4] <= alu_out;
        cy       <= alu_c_out;
      end
    end
  end

endmodule
